// File: rtl/dp_ram_sync_param_pkg.sv
// Shared types and byte-merge helper for the parametrised dual-port RAM and its models.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ram_pkg;

   typedef enum logic {INIT, RUN} ram_state_e;

   typedef enum bit {READ_FIRST, WRITE_FIRST} rdw_mode_e;

   // One byte lane of a byte-enabled write: the new byte wins only where its enable is set.
   // Callers loop this over lanes, so the helper stays width-agnostic.
   function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                           input logic [7:0] new_b,
                                           input logic       be);
      return be ? new_b : old_b;
   endfunction

endpackage

// File: rtl/dp_ram_sync_param_if.sv
// Write/read port bundle for dp_ram_sync_param; master drives requests, slave is the RAM.
// Latency: n/a (wiring only).
// Backpressure: none; the RAM never stalls, init_busy tells the master requests are ignored.
interface dp_ram_sync_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
);
   logic                  we;
   logic [ADDR_W-1:0]     w_add;
   logic [DATA_W/8-1:0]   wbe;
   logic [DATA_W-1:0]     data_in;
   logic                  re;
   logic [ADDR_W-1:0]     r_add;
   logic [DATA_W-1:0]     data_out;
   logic                  rvalid;
   logic                  rd_err;
   logic                  init_busy;

   modport master (
      output we, w_add, wbe, data_in, re, r_add,
      input  data_out, rvalid, rd_err, init_busy
   );

   modport slave (
      input  we, w_add, wbe, data_in, re, r_add,
      output data_out, rvalid, rd_err, init_busy
   );
endinterface

// File: rtl/dp_ram_rd_pipe.sv
// Read output pipeline: registers raw read data/valid/err into data_out/rvalid/rd_err.
// Latency: RD_LAT (1 or 2) cycles from accepted read to rvalid.
// Backpressure: none; fully pipelined, reset flushes every in-flight read.
module dp_ram_rd_pipe #(
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_vld,
   input  logic              rd_err_in,
   input  logic [DATA_W-1:0] rd_dat,
   output logic [DATA_W-1:0] data_out,
   output logic              rvalid,
   output logic              rd_err
);
   logic              s1_vld;
   logic              s1_err;
   logic [DATA_W-1:0] s1_dat;

   // First stage: data only moves on a real read so the output holds between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s1_err <= 1'b0;
         s1_dat <= '0;
      end else begin
         s1_vld <= rd_vld;
         s1_err <= rd_vld & rd_err_in;
         if (rd_vld) s1_dat <= rd_dat;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              s2_vld;
         logic              s2_err;
         logic [DATA_W-1:0] s2_dat;

         // Extra output stage, same hold-on-idle behaviour as the first.
         always_ff @(posedge clk) begin
            if (reset) begin
               s2_vld <= 1'b0;
               s2_err <= 1'b0;
               s2_dat <= '0;
            end else begin
               s2_vld <= s1_vld;
               s2_err <= s1_err;
               if (s1_vld) s2_dat <= s1_dat;
            end
         end

         assign data_out = s2_dat;
         assign rvalid   = s2_vld;
         assign rd_err   = s2_err;
      end else begin : g_lat1
         assign data_out = s1_dat;
         assign rvalid   = s1_vld;
         assign rd_err   = s1_err;
      end
   endgenerate
endmodule

// File: rtl/dp_ram_sync_param.sv
// Parametrised 1W/1R synchronous RAM with byte enables, RDW policy and post-reset clear.
// Latency: read data and rvalid RD_LAT cycles after re; writes land at the same posedge.
// Backpressure: none; ports are ignored while init_busy is high (DEPTH cycles after reset).
module dp_ram_sync_param
   import ram_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0
) (
   input  logic                clk,
   input  logic                reset,
   dp_ram_sync_param_if.slave  bus
);
   localparam int               BE_W     = DATA_W / 8;
   localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam rdw_mode_e        RDW      = rdw_mode_e'(RDW_MODE[0]);

   generate
      if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_data_w
         $fatal(1, "dp_ram_sync_param: DATA_W must be a non-zero multiple of 8");
      end
      if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
         $fatal(1, "dp_ram_sync_param: RD_LAT must be 1 or 2");
      end
      if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
         $fatal(1, "dp_ram_sync_param: RDW_MODE must be 0 or 1");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $fatal(1, "dp_ram_sync_param: DEPTH must be at least 2");
      end
   endgenerate

   ram_state_e        state_q;
   logic [ADDR_W-1:0] init_cnt_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              run;
   logic              wr_in_rng;
   logic              rd_in_rng;
   logic              wr_ok;
   logic              rd_ok;
   logic              collide;
   logic [ADDR_W-1:0] w_idx;
   logic [ADDR_W-1:0] r_idx;
   logic [DATA_W-1:0] wr_merged;
   logic [DATA_W-1:0] rd_raw;

   // Address qualification, byte merge and read-during-write selection.
   // Out-of-range addresses are steered to entry 0 so the array is never indexed past DEPTH.
   always_comb begin
      run       = (state_q == RUN);
      wr_in_rng = ({1'b0, bus.w_add} < DEPTH_L);
      rd_in_rng = ({1'b0, bus.r_add} < DEPTH_L);
      w_idx     = wr_in_rng ? bus.w_add : '0;
      r_idx     = rd_in_rng ? bus.r_add : '0;
      wr_ok     = run & bus.we & wr_in_rng;
      rd_ok     = run & bus.re;
      collide   = wr_ok & rd_in_rng & (bus.r_add == bus.w_add);
      wr_merged = '0;
      for (int i = 0; i < BE_W; i++) begin
         wr_merged[8*i +: 8] = be_merge(mem[w_idx][8*i +: 8], bus.data_in[8*i +: 8], bus.wbe[i]);
      end
      rd_raw = '0;
      if (rd_in_rng) begin
         rd_raw = (collide && RDW == WRITE_FIRST) ? wr_merged : mem[r_idx];
      end
   end

   // Init FSM: walk init_cnt over every entry once, then sit in RUN until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
      end else if (state_q == INIT) begin
         if (init_cnt_q == LAST_IDX) begin
            state_q    <= RUN;
            init_cnt_q <= '0;
         end else begin
            init_cnt_q <= init_cnt_q + ADDR_W'(1);
         end
      end
   end

   // Array write port: init clear has priority; the array is left alone while reset is high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == INIT) begin
            mem[init_cnt_q] <= '0;
         end else if (wr_ok) begin
            mem[w_idx] <= wr_merged;
         end
      end
   end

   assign bus.init_busy = (state_q == INIT);

   dp_ram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .rd_vld    (rd_ok),
      .rd_err_in (~rd_in_rng),
      .rd_dat    (rd_raw),
      .data_out  (bus.data_out),
      .rvalid    (bus.rvalid),
      .rd_err    (bus.rd_err)
   );
endmodule

// File: tb/tb_dp_ram_sync_param.sv
// Directed bench: u0 = defaults, u1 = RD_LAT 2 + WRITE_FIRST (mirrors u0 stimulus),
// u2 = 32-bit x 12 entries for byte enables and out-of-range accesses.
// Outputs are sampled on the falling edge, inputs change right after it.
module tb_dp_ram_sync_param;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   nb;
   int   rv0_cnt;
   int   rv1_cnt;
   int   rv_init;
   logic [31:0] exp32;

   always #5 clk = ~clk;

   dp_ram_sync_param_if #(.DATA_W(8),  .DEPTH(16)) if0 ();
   dp_ram_sync_param_if #(.DATA_W(8),  .DEPTH(16)) if1 ();
   dp_ram_sync_param_if #(.DATA_W(32), .DEPTH(12)) if2 ();

   assign if1.we      = if0.we;
   assign if1.w_add   = if0.w_add;
   assign if1.wbe     = if0.wbe;
   assign if1.data_in = if0.data_in;
   assign if1.re      = if0.re;
   assign if1.r_add   = if0.r_add;

   dp_ram_sync_param #(.DATA_W(8), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0))
      u0 (.clk(clk), .reset(reset), .bus(if0.slave));
   dp_ram_sync_param #(.DATA_W(8), .DEPTH(16), .RD_LAT(2), .RDW_MODE(1))
      u1 (.clk(clk), .reset(reset), .bus(if1.slave));
   dp_ram_sync_param #(.DATA_W(32), .DEPTH(12), .RD_LAT(1), .RDW_MODE(0))
      u2 (.clk(clk), .reset(reset), .bus(if2.slave));

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      if0.we = 1'b0; if0.w_add = '0; if0.wbe = '0; if0.data_in = '0; if0.re = 1'b0; if0.r_add = '0;
      if2.we = 1'b0; if2.w_add = '0; if2.wbe = '0; if2.data_in = '0; if2.re = 1'b0; if2.r_add = '0;
      cyc();

      // Reset state
      chk("rst_dout",  if0.data_out, 8'h00);
      chk("rst_rv",    if0.rvalid, 1'b0);
      chk("rst_err",   if0.rd_err, 1'b0);
      chk("rst_busy",  if0.init_busy, 1'b1);
      chk("rst_busy2", if2.init_busy, 1'b1);
      reset = 1'b0;

      // Write 0xAA to addr 3 and read addr 3 on every INIT cycle: all must be ignored
      if0.we = 1'b1; if0.w_add = 4'd3; if0.data_in = 8'hAA; if0.wbe = 1'b1;
      if0.re = 1'b1; if0.r_add = 4'd3;
      nb = 0; rv_init = 0;
      while (if0.init_busy && nb < 40) begin
         nb++;
         cyc();
         if (if0.rvalid || if1.rvalid) rv_init++;
      end
      chk("init_len",    nb, 16);
      chk("init_no_rv",  rv_init, 0);
      chk("init_done1",  if1.init_busy, 1'b0);
      chk("init_done2",  if2.init_busy, 1'b0);
      if0.we = 1'b0;
      cyc();
      chk("init_rd_rv",  if0.rvalid, 1'b1);
      chk("init_rd_dat", if0.data_out, 8'h00);
      chk("lat2_early",  if1.rvalid, 1'b0);
      if0.re = 1'b0;
      cyc();
      chk("rv_pulse",    if0.rvalid, 1'b0);
      chk("lat2_rv",     if1.rvalid, 1'b1);
      chk("lat2_dat",    if1.data_out, 8'h00);
      cyc();

      // Write 0x5A to addr 15, read back with both latencies
      if0.we = 1'b1; if0.w_add = 4'd15; if0.data_in = 8'h5A; if0.wbe = 1'b1;
      cyc();
      if0.we = 1'b0; if0.re = 1'b1; if0.r_add = 4'd15;
      cyc();
      chk("a15_rv",      if0.rvalid, 1'b1);
      chk("a15_dat",     if0.data_out, 8'h5A);
      chk("a15_lat2_0",  if1.rvalid, 1'b0);
      if0.re = 1'b0;
      cyc();
      chk("a15_rv_off",  if0.rvalid, 1'b0);
      chk("a15_hold",    if0.data_out, 8'h5A);
      chk("a15_lat2_rv", if1.rvalid, 1'b1);
      chk("a15_lat2_d",  if1.data_out, 8'h5A);
      cyc();
      chk("a15_lat2_off", if1.rvalid, 1'b0);

      // Same-address collision on addr 7: old 0x10, new 0x20
      if0.we = 1'b1; if0.w_add = 4'd7; if0.data_in = 8'h10;
      cyc();
      if0.data_in = 8'h20; if0.re = 1'b1; if0.r_add = 4'd7;
      cyc();
      chk("col_rf_rv",  if0.rvalid, 1'b1);
      chk("col_rf_dat", if0.data_out, 8'h10);
      if0.we = 1'b0; if0.re = 1'b0;
      cyc();
      chk("col_wf_rv",  if1.rvalid, 1'b1);
      chk("col_wf_dat", if1.data_out, 8'h20);
      if0.re = 1'b1;
      cyc();
      chk("a7_after_rf", if0.data_out, 8'h20);
      if0.re = 1'b0;
      cyc();
      chk("a7_after_wf", if1.data_out, 8'h20);

      // Write addr 8 while reading addr 15 in the same cycle: independent
      if0.we = 1'b1; if0.w_add = 4'd8; if0.data_in = 8'h33; if0.re = 1'b1; if0.r_add = 4'd15;
      cyc();
      chk("diff_rd",    if0.data_out, 8'h5A);
      if0.we = 1'b0; if0.r_add = 4'd8;
      cyc();
      chk("diff_wr",    if0.data_out, 8'h33);
      chk("diff_rd_l2", if1.data_out, 8'h5A);
      if0.re = 1'b0;
      cyc();
      chk("diff_wr_l2", if1.data_out, 8'h33);

      // Seed addr 0 so the post-reset clear is visible there
      if0.we = 1'b1; if0.w_add = 4'd0; if0.data_in = 8'h77;
      cyc();
      if0.we = 1'b0;
      cyc();

      // 32-bit byte enables on u2: 0x11223344 then 0xAABBCCDD under 0101
      if2.we = 1'b1; if2.w_add = 4'd2; if2.data_in = 32'h11223344; if2.wbe = 4'b1111;
      cyc();
      if2.data_in = 32'hAABBCCDD; if2.wbe = 4'b0101;
      cyc();
      if2.we = 1'b0; if2.re = 1'b1; if2.r_add = 4'd2;
      cyc();
      chk("be_rv",  if2.rvalid, 1'b1);
      chk("be_dat", if2.data_out, 32'h11BB33DD);

      // Out-of-range reads on DEPTH=12
      if2.r_add = 4'd13;
      cyc();
      chk("oor13_rv",  if2.rvalid, 1'b1);
      chk("oor13_err", if2.rd_err, 1'b1);
      chk("oor13_dat", if2.data_out, 32'h0);
      if2.re = 1'b0;
      cyc();
      chk("oor_rv_off",  if2.rvalid, 1'b0);
      chk("oor_err_off", if2.rd_err, 1'b0);
      if2.re = 1'b1; if2.r_add = 4'd12;
      cyc();
      chk("oor12_err", if2.rd_err, 1'b1);
      if2.r_add = 4'd11;
      cyc();
      chk("last_err",  if2.rd_err, 1'b0);
      if2.re = 1'b0;

      // Out-of-range writes are dropped: whole array must be unchanged
      if2.we = 1'b1; if2.w_add = 4'd13; if2.data_in = 32'hFFFFFFFF; if2.wbe = 4'b1111;
      cyc();
      if2.w_add = 4'd12;
      cyc();
      if2.we = 1'b0; if2.re = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if2.r_add = 4'(i);
         cyc();
         exp32 = (i == 2) ? 32'h11BB33DD : 32'h0;
         chk("oor_wr_sweep", if2.data_out, exp32);
      end
      if2.re = 1'b0;
      cyc();
      cyc();

      // Back-to-back reads 0..3 with reset landing on the second read
      rv0_cnt = 0; rv1_cnt = 0;
      if0.re = 1'b1; if0.r_add = 4'd0;
      cyc();
      chk("mid_rd0", if0.data_out, 8'h77);
      rv0_cnt += int'(if0.rvalid); rv1_cnt += int'(if1.rvalid);
      if0.r_add = 4'd1; reset = 1'b1;
      cyc();
      chk("mid_rv_flush", if0.rvalid, 1'b0);
      chk("mid_busy",     if0.init_busy, 1'b1);
      chk("mid_dout",     if0.data_out, 8'h00);
      rv0_cnt += int'(if0.rvalid); rv1_cnt += int'(if1.rvalid);
      reset = 1'b0; if0.r_add = 4'd2;
      nb = 0;
      while (if0.init_busy && nb < 40) begin
         nb++;
         cyc();
         rv0_cnt += int'(if0.rvalid); rv1_cnt += int'(if1.rvalid);
         if (nb == 1) if0.r_add = 4'd3;
         else         if0.re = 1'b0;
      end
      chk("reinit_len", nb, 16);
      chk("mid_rv_cnt", rv0_cnt, 1);
      chk("mid_rv_l2",  rv1_cnt, 0);

      // Every entry cleared again
      if0.re = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if0.r_add = 4'(i);
         cyc();
         chk("clear_sweep", {if0.rvalid, if0.data_out}, 9'h100);
      end
      if0.re = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
